// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared pipeline register types, mem-stage FSM states and constants
package rv32_pkg;

  localparam logic [3:0] MEM_BE_WORD = 4'hF;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        valid;
  } ex_mem_pipeline_reg_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        valid;
  } mem_wb_pipeline_reg_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT_GNT,
    MEM_WAIT_RVALID
  } mem_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_if_fsm.sv
// rtl/dmem_if_fsm.sv - req/gnt/rvalid data-bus handshake FSM and pipeline stall generation
module dmem_if_fsm
  import rv32_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_memop,
  input  logic              i_store,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_gnt,
  input  logic              i_rvalid,
  output logic              o_req,
  output logic              o_we,
  output logic [DATA_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_be,
  output logic              o_stall,
  output logic              o_load_done
);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;

  // Request fields are captured on issue so they stay put across WAIT_GNT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= MEM_IDLE;
      r_addr  <= RESET_ADDR;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == MEM_IDLE && i_memop) begin
        r_addr  <= word_align(i_addr);
        r_wdata <= i_wdata;
        r_we    <= i_store;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_req       = 1'b0;
    o_we        = 1'b0;
    o_addr      = RESET_ADDR;
    o_wdata     = '0;
    o_be        = '0;
    o_stall     = 1'b0;
    o_load_done = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (i_memop) begin
          o_req   = 1'b1;
          o_we    = i_store;
          o_addr  = word_align(i_addr);
          o_wdata = i_wdata;
          o_be    = MEM_BE_WORD;
          o_stall = !(i_gnt && i_store);
          if (i_gnt) w_next = i_store ? MEM_IDLE : MEM_WAIT_RVALID;
          else       w_next = MEM_WAIT_GNT;
        end
      end
      MEM_WAIT_GNT: begin
        o_req   = 1'b1;
        o_we    = r_we;
        o_addr  = r_addr;
        o_wdata = r_wdata;
        o_be    = MEM_BE_WORD;
        o_stall = !(i_gnt && r_we);
        if (i_gnt) w_next = r_we ? MEM_IDLE : MEM_WAIT_RVALID;
      end
      MEM_WAIT_RVALID: begin
        o_stall = !i_rvalid;
        if (i_rvalid) begin
          o_load_done = 1'b1;
          w_next      = MEM_IDLE;
        end
      end
      default: w_next = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: data-bus access, mem/wb register, forwarding
// Optional misaligned-access trap selected by MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage
  import rv32_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  ex_mem_pipeline_reg_t ex_mem_i,
  output logic                 data_req_o,
  output logic                 data_we_o,
  output logic [DATA_W-1:0]    data_addr_o,
  output logic [DATA_W-1:0]    data_wdata_o,
  output logic [3:0]           data_be_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic [DATA_W-1:0]    data_rdata_i,
  output logic                 stall_o,
  output logic [DATA_W-1:0]    fwd_data_o,
  output logic                 misaligned_o,
  output mem_wb_pipeline_reg_t mem_wb_o
);

  logic                 w_memop;
  logic                 w_store;
  logic                 w_misaligned;
  logic                 w_bus_memop;
  logic                 w_stall;
  logic                 w_load_done;
  mem_wb_pipeline_reg_t r_mem_wb;

  assign w_memop = ex_mem_i.valid & (ex_mem_i.mem_read | ex_mem_i.mem_write);
  assign w_store = ex_mem_i.mem_write;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic r_misaligned;

  assign w_misaligned = w_memop & (ex_mem_i.alu_result[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_misaligned <= 1'b0;
    else         r_misaligned <= w_misaligned;
  end

  assign misaligned_o = r_misaligned;
`else
  assign w_misaligned = 1'b0;
  assign misaligned_o = 1'b0;
`endif

  assign w_bus_memop = w_memop & ~w_misaligned;

  dmem_if_fsm #(
    .DATA_W     (DATA_W),
    .RESET_ADDR (RESET_ADDR)
  ) u_dmem_if_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_memop     (w_bus_memop),
    .i_store     (w_store),
    .i_addr      (ex_mem_i.alu_result),
    .i_wdata     (ex_mem_i.rs2_data),
    .i_gnt       (data_gnt_i),
    .i_rvalid    (data_rvalid_i),
    .o_req       (data_req_o),
    .o_we        (data_we_o),
    .o_addr      (data_addr_o),
    .o_wdata     (data_wdata_o),
    .o_be        (data_be_o),
    .o_stall     (w_stall),
    .o_load_done (w_load_done)
  );

  // Stall edges insert a bubble; data fields are held for the write-back stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem_wb <= '0;
    end else if (w_stall) begin
      r_mem_wb.valid     <= 1'b0;
      r_mem_wb.reg_write <= 1'b0;
    end else begin
      r_mem_wb.result    <= w_load_done ? data_rdata_i : ex_mem_i.alu_result;
      r_mem_wb.rd_addr   <= ex_mem_i.rd_addr;
      r_mem_wb.reg_write <= ex_mem_i.reg_write & ~w_store & ~w_misaligned;
      r_mem_wb.valid     <= ex_mem_i.valid;
    end
  end

  assign stall_o    = w_stall;
  assign fwd_data_o = ex_mem_i.alu_result;
  assign mem_wb_o   = r_mem_wb;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage with a transaction-level model
module tb_mem_stage;
  import rv32_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic                 clk_i;
  logic                 rst_ni;
  ex_mem_pipeline_reg_t ex_mem_i;
  logic                 data_req_o;
  logic                 data_we_o;
  logic [31:0]          data_addr_o;
  logic [31:0]          data_wdata_o;
  logic [3:0]           data_be_o;
  logic                 data_gnt_i;
  logic                 data_rvalid_i;
  logic [31:0]          data_rdata_i;
  logic                 stall_o;
  logic [31:0]          fwd_data_o;
  logic                 misaligned_o;
  mem_wb_pipeline_reg_t mem_wb_o;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.DATA_W(32), .RESET_ADDR(RST_ADDR)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ex_mem_i      (ex_mem_i),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_be_o     (data_be_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .stall_o       (stall_o),
    .fwd_data_o    (fwd_data_o),
    .misaligned_o  (misaligned_o),
    .mem_wb_o      (mem_wb_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  // One instruction as a bus transaction: the slave grants gd cycles after the first
  // request and (loads) returns data rdly>=1 cycles after the grant.
  task automatic run_op(input logic is_ld, input logic is_st, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                        input int gd, input int rdly, input logic [31:0] rdata,
                        input string name);
    ex_mem_pipeline_reg_t op;
    logic memop, mis, is_load, exp_req;
    int total;
    bit done;
    mem_wb_pipeline_reg_t exp_wb;
    op      = '{addr, rs2, rd, rw, is_ld, is_st, 1'b1};
    memop   = is_ld | is_st;
    is_load = is_ld & ~is_st;
    mis     = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    mis = memop && (addr[1:0] != 2'b00);
`endif
    if (!memop || mis) total = 0;
    else if (is_st)    total = gd;
    else               total = gd + rdly;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk_i);
      ex_mem_i      = op;
      data_rdata_i  = rdata;
      data_gnt_i    = memop && !mis && (c == gd);
      if (is_load && !mis && c == gd + rdly) data_rvalid_i = 1'b1;
      else if (c < gd)                       data_rvalid_i = 1'($urandom_range(0, 1));
      else                                   data_rvalid_i = 1'b0;
      #1;
      exp_req = memop && !mis && (c <= gd);
      vectors++;
      if ({data_req_o, stall_o} !== {exp_req, (c < total)}) begin
        miscompares++;
        $display("FAIL %s req/stall cyc%0d: got %b%b want %b%b", name, c,
                 data_req_o, stall_o, exp_req, (c < total));
      end
      if (exp_req) begin
        vectors++;
        if ({data_addr_o, data_wdata_o, data_we_o, data_be_o} !==
            {addr & 32'hFFFF_FFFC, rs2, is_st, 4'hF}) begin
          miscompares++;
          $display("FAIL %s bus cyc%0d: got addr %h wd %h we %b be %h want addr %h wd %h we %b be f",
                   name, c, data_addr_o, data_wdata_o, data_we_o, data_be_o,
                   addr & 32'hFFFF_FFFC, rs2, is_st);
        end
      end else if (c == 0) begin
        vectors++;
        if ({data_addr_o, data_be_o} !== {RST_ADDR, 4'h0}) begin
          miscompares++;
          $display("FAIL %s idle bus: got addr %h be %h want %h 0", name, data_addr_o,
                   data_be_o, RST_ADDR);
        end
      end
      vectors++;
      if (fwd_data_o !== addr) begin
        miscompares++;
        $display("FAIL %s fwd: got %h want %h", name, fwd_data_o, addr);
      end
      if (c >= 1 && c <= total) begin
        vectors++;
        if ({mem_wb_o.valid, mem_wb_o.reg_write} !== 2'b00) begin
          miscompares++;
          $display("FAIL %s bubble cyc%0d: got valid/rw %b%b want 00", name, c,
                   mem_wb_o.valid, mem_wb_o.reg_write);
        end
      end
      if (c == total) done = 1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL %s timeout: got no completion want completion in %0d cycles", name, total);
    end
    @(posedge clk_i);
    #1;
    exp_wb = '{(is_load && !mis) ? rdata : addr, rd, rw && !is_st && !mis, 1'b1};
    vectors++;
    if ({mem_wb_o, misaligned_o} !== {exp_wb, mis}) begin
      miscompares++;
      $display("FAIL %s mem_wb: got %h/%0d/%b/%b mis %b want %h/%0d/%b/%b mis %b", name,
               mem_wb_o.result, mem_wb_o.rd_addr, mem_wb_o.reg_write, mem_wb_o.valid,
               misaligned_o, exp_wb.result, exp_wb.rd_addr, exp_wb.reg_write, exp_wb.valid, mis);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({data_req_o, data_we_o, data_addr_o, data_wdata_o, data_be_o, stall_o, mem_wb_o,
         misaligned_o} !== {1'b0, 1'b0, RST_ADDR, 32'h0, 4'h0, 1'b0, 39'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got req %b we %b addr %h wd %h be %h stall %b wb %h mis %b want all zero, addr %h",
               name, data_req_o, data_we_o, data_addr_o, data_wdata_o, data_be_o, stall_o,
               mem_wb_o, misaligned_o, RST_ADDR);
    end
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    ex_mem_i      = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_alu();
    run_op(0, 0, 32'h1234, $urandom, 5'd5, 1'b1, 0, 0, 32'h0, "alu_basic");
    for (int i = 0; i < 4; i++)
      run_op(0, 0, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0, 32'h0, "alu_rand");
  endtask

  task automatic test_store();
    run_op(0, 1, 32'h100, 32'hDEAD_BEEF, 5'd7, 1'b1, 0, 0, 32'h0, "store_gnt");
    run_op(0, 1, 32'h104, $urandom, 5'd8, 1'b1, 3, 0, 32'h0, "store_late_gnt");
  endtask

  task automatic test_load_delay();
    run_op(1, 0, 32'h200, $urandom, 5'd9, 1'b1, 2, 1, 32'hCAFE_F00D, "load_delay");
    run_op(1, 0, 32'h204, $urandom, 5'd10, 1'b1, 0, 3, $urandom, "load_slow_rvalid");
  endtask

  task automatic test_back_to_back();
    run_op(0, 1, 32'h300, $urandom, 5'd1, 1'b0, 0, 0, 32'h0, "b2b_store0");
    run_op(0, 1, 32'h304, $urandom, 5'd2, 1'b0, 0, 0, 32'h0, "b2b_store1");
    run_op(1, 0, 32'h308, $urandom, 5'd3, 1'b1, 0, 1, $urandom, "b2b_load");
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk_i);
    ex_mem_i      = '{32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1};
    data_gnt_i    = 1'b1;
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_load pre: got stall %b want 1", stall_o);
    end
    ex_mem_i = '0;
    rst_ni   = 1'b0;
    #1;
    check_reset_outputs("rst_mid_load");
    @(negedge clk_i);
    rst_ni        = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5555_AAAA;
    #1;
    vectors++;
    if ({stall_o, data_req_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_late_rvalid: got stall/req %b%b want 00", stall_o, data_req_o);
    end
    @(posedge clk_i);
    #1;
    vectors++;
    if (mem_wb_o.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_late_rvalid wb: got valid %b want 0", mem_wb_o.valid);
    end
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    run_op(1, 0, 32'h408, $urandom, 5'd6, 1'b1, 1, 1, $urandom, "load_after_rst");
  endtask

  task automatic test_misalign();
    run_op(1, 0, 32'h203, $urandom, 5'd11, 1'b1, 0, 1, $urandom, "misalign_load");
    run_op(0, 1, 32'h302, $urandom, 5'd12, 1'b1, 0, 0, 32'h0, "misalign_store");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom);
      run_op(kind[0], kind[1], $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(1, 3), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load_delay();
    test_back_to_back();
    test_reset_mid_load();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
